// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam logic [2:0] FUNC3_WORD = 3'b010;
endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// arb_streak_counter: saturating count of consecutive data grants made while fetch waits
//   clk, rst_n : clock, synchronous active-low reset
//   inc, clr   : count up (saturating) / clear; clr wins
//   at_max     : count equals MAX_STREAK
module arb_streak_counter #(
  parameter int MAX_STREAK = 4,
  localparam int W = $clog2(MAX_STREAK + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max = cnt_q == W'(MAX_STREAK);
  always_comb cnt_d = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read memory port between fetch and load/store
//   if_req/if_addr -> if_gnt, if_rvalid/if_rdata      : fetch side (word reads)
//   d_req/d_we/d_addr/d_wdata/d_func3 -> d_gnt, d_rvalid/d_rdata : data side (priority)
//   mem_addr/mem_wen/mem_wd/mem_func3, mem_rd         : memory port, 1-cycle read latency
//   clk, rst_n                                        : clock, synchronous active-low reset
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wd,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rd
);
  owner_t rd_owner_q, rd_owner_d;
  logic   at_max;
  arb_streak_counter #(.MAX_STREAK(MAX_STREAK)) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (d_gnt && if_req),
    .clr    (!if_req || if_gnt),
    .at_max (at_max)
  );
  // Grants and returned data are masked while reset is held so an in-flight read never surfaces.
  always_comb begin
    d_gnt      = rst_n && d_req && !(if_req && at_max);
    if_gnt     = rst_n && if_req && !d_gnt;
    mem_addr   = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_func3  = d_gnt ? d_func3 : FUNC3_WORD;
    mem_wen    = d_gnt && d_we;
    mem_wd     = mem_wen ? d_wdata : '0;
    rd_owner_d = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
    if_rvalid  = rst_n && rd_owner_q == OWN_IF;
    d_rvalid   = rst_n && rd_owner_q == OWN_D;
    if_rdata   = if_rvalid ? mem_rd : '0;
    d_rdata    = d_rvalid ? mem_rd : '0;
  end
  always_ff @(posedge clk) rd_owner_q <= !rst_n ? OWN_NONE : rd_owner_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random traffic against a reference model
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  logic        clk = 1'b0;
  logic        rst_n, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rd;
  logic [2:0]  d_func3;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wen;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wd;
  logic [2:0]  mem_func3;
  int tests = 0, failed = 0;
  int m_streak = 0, m_own = 0;
  logic e_dg, e_ig;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_func3(d_func3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wd(mem_wd), .mem_func3(mem_func3), .mem_rd(mem_rd)
  );
  typedef struct {
    logic r, ir; logic [31:0] ia; logic dr, dw; logic [31:0] da, dwd; logic [2:0] f3; logic [31:0] mrd;
    logic ig, dg, iv, dv, wen; logic [31:0] addr, wd, ird, drd; logic [2:0] ef3;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply(input logic r, ir, input logic [31:0] ia, input logic dr, dw,
                       input logic [31:0] da, dwd, input logic [2:0] f3, input logic [31:0] mrd);
    rst_n = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dwd; d_func3 = f3; mem_rd = mrd;
    #2;
  endtask
  task automatic model_chk();
    e_dg = rst_n && d_req && !(if_req && m_streak == MAX);
    e_ig = rst_n && if_req && !e_dg;
    chk("m_if_gnt", if_gnt, e_ig);
    chk("m_d_gnt", d_gnt, e_dg);
    chk("m_if_rvalid", if_rvalid, rst_n && m_own == 1);
    chk("m_d_rvalid", d_rvalid, rst_n && m_own == 2);
    chk("m_if_rdata", if_rdata, (rst_n && m_own == 1) ? mem_rd : 32'h0);
    chk("m_d_rdata", d_rdata, (rst_n && m_own == 2) ? mem_rd : 32'h0);
    chk("m_mem_addr", mem_addr, e_dg ? d_addr : e_ig ? if_addr : 32'h0);
    chk("m_mem_wen", mem_wen, e_dg && d_we);
    chk("m_mem_wd", mem_wd, (e_dg && d_we) ? d_wdata : 32'h0);
    chk("m_mem_func3", mem_func3, e_dg ? d_func3 : 3'b010);
  endtask
  task automatic adv();
    if (!rst_n) begin
      m_own = 0; m_streak = 0;
    end else begin
      m_own = e_ig ? 1 : (e_dg && !d_we) ? 2 : 0;
      m_streak = (e_dg && if_req) ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input logic [31:0] mrd);
    apply(1, 0, 0, 0, 0, 0, 0, 3'b010, mrd);
  endtask
  initial begin
    string seq;
    byte g;
    vt[0] = '{0,1,32'h10,1,0,32'h44,32'h0,3'b010,32'h0,   0,0,0,0,0,32'h0,32'h0,32'h0,32'h0,3'b010};
    vt[1] = '{0,1,32'h10,1,0,32'h44,32'h0,3'b010,32'h0,   0,0,0,0,0,32'h0,32'h0,32'h0,32'h0,3'b010};
    vt[2] = '{1,1,32'h10,0,0,32'h0,32'h0,3'b000,32'h0,    1,0,0,0,0,32'h10,32'h0,32'h0,32'h0,3'b010};
    vt[3] = '{1,0,32'h0,0,0,32'h0,32'h0,3'b000,32'hDEADBEEF, 0,0,1,0,0,32'h0,32'h0,32'hDEADBEEF,32'h0,3'b010};
    vt[4] = '{1,0,32'h0,1,1,32'h40,32'h55,3'b000,32'h0,   0,1,0,0,1,32'h40,32'h55,32'h0,32'h0,3'b000};
    vt[5] = '{1,0,32'h0,0,0,32'h0,32'h0,3'b010,32'h1234,  0,0,0,0,0,32'h0,32'h0,32'h0,32'h0,3'b010};
    vt[6] = '{1,1,32'h20,0,0,32'h0,32'h0,3'b010,32'h0,    1,0,0,0,0,32'h20,32'h0,32'h0,32'h0,3'b010};
    vt[7] = '{1,0,32'h0,1,0,32'h80,32'h0,3'b010,32'h11111111, 0,1,1,0,0,32'h80,32'h0,32'h11111111,32'h0,3'b010};
    vt[8] = '{1,0,32'h0,0,0,32'h0,32'h0,3'b010,32'h22222222, 0,0,0,1,0,32'h0,32'h0,32'h0,32'h22222222,3'b010};
    vt[9] = '{1,0,32'h0,0,0,32'h0,32'h0,3'b010,32'h33333333, 0,0,0,0,0,32'h0,32'h0,32'h0,32'h0,3'b010};
    for (int i = 0; i < 10; i++) begin
      apply(vt[i].r, vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dwd, vt[i].f3, vt[i].mrd);
      chk($sformatf("v%0d_if_gnt", i), if_gnt, vt[i].ig);
      chk($sformatf("v%0d_d_gnt", i), d_gnt, vt[i].dg);
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vt[i].iv);
      chk($sformatf("v%0d_d_rvalid", i), d_rvalid, vt[i].dv);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, vt[i].wen);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("v%0d_mem_wd", i), mem_wd, vt[i].wd);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].ird);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].drd);
      chk($sformatf("v%0d_mem_func3", i), mem_func3, vt[i].ef3);
      model_chk();
      adv();
    end
    seq = "DDDDID";
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, 32'h100, 1, 1, 32'h200, 32'hA5, 3'b010, 32'h0);
      g = d_gnt ? "D" : if_gnt ? "I" : "-";
      chk($sformatf("contention_%0d", i), {24'h0, g}, {24'h0, seq[i]});
      model_chk();
      adv();
    end
    idle(0); model_chk(); adv();
    apply(1, 0, 0, 1, 0, 32'h90, 0, 3'b010, 32'h0);
    chk("midrst_load_gnt", d_gnt, 1);
    model_chk(); adv();
    apply(0, 0, 0, 0, 0, 0, 0, 3'b010, 32'h77777777);
    chk("midrst_rvalid_in_rst", d_rvalid, 0);
    chk("midrst_rdata_in_rst", d_rdata, 0);
    model_chk(); adv();
    idle(32'h88888888);
    chk("midrst_rvalid_after", d_rvalid, 0);
    model_chk(); adv();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 19) != 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1), $urandom, $urandom, 3'($urandom), $urandom);
      model_chk();
      adv();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
